// File: rtl/dram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// dram_fifo_ctrl
//
// Synchronous 32-deep FIFO on RAM32M-style distributed RAM in simple-dual-port
// mode. Each primitive holds 6 data bits. Port D (ADDRD) takes the write
// address and ports A/B/C take the read address. The block owns the pointers,
// the occupancy counter, the status flags and the registered read stage.
//
// Parameters
//   WIDTH   data width in bits; must be a multiple of 6 (WIDTH/6 primitives)
//   AFULL   almost_full_o  asserts when level >= AFULL  (1..32)
//   AEMPTY  almost_empty_o asserts when level <= AEMPTY (0..31)
//
// Ports
//   clock_i         sole clock, also the RAM write clock
//   reset_i         asynchronous, active-high reset
//   write_i/data_i  push request and push data, sampled on the rising edge
//   read_i          pop request, sampled on the rising edge
//   data_o/valid_o  registered pop data; valid_o is high for exactly one cycle
//                   after each accepted pop
//   empty_o/full_o  level == 0 / level == 32
//   almost_full_o   level >= AFULL
//   almost_empty_o  level <= AEMPTY
//   level_o         occupancy, 0..32
//   overflow_o      sticky: a push was rejected (cleared only by reset)
//   underflow_o     sticky: a pop was rejected  (cleared only by reset)
// -----------------------------------------------------------------------------
module dram_fifo_ctrl #(
  parameter int WIDTH  = 6,
  parameter int AFULL  = 28,
  parameter int AEMPTY = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             write_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             read_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [5:0]       level_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int NPRIM = WIDTH / 6;
  localparam int DEPTH = 32;

  logic [4:0]       wptr;
  logic [4:0]       rptr;
  logic [5:0]       level;
  logic             wr_ok;
  logic             rd_ok;
  logic [WIDTH-1:0] ram_dout;

  // ---------------------------------------------------------------------------
  // Flags decode combinationally from the registered level only.
  // ---------------------------------------------------------------------------
  assign empty_o        = (level == 6'd0);
  assign full_o         = (level == 6'd32);
  assign almost_full_o  = (level >= 6'(AFULL));
  assign almost_empty_o = (level <= 6'(AEMPTY));
  assign level_o        = level;

  // A push into a full FIFO is legal only when a pop frees a slot in the same
  // cycle. A pop on empty is never served from a same-cycle push, so there is
  // no bypass path from data_i to data_o.
  assign wr_ok = write_i & (~full_o | read_i);
  assign rd_ok = read_i & ~empty_o;

  // ---------------------------------------------------------------------------
  // Distributed RAM, one RAM32M-equivalent per 6-bit slice.
  // A RAM32M writes all four 32x2 arrays at ADDRD. With ADDRA/B/C tied to rptr,
  // arrays A/B/C form a 32x6 simple-dual-port RAM. Port D's DID is tied to 0
  // and DOD is unused, so array D carries no information and is not modelled.
  // Slice mapping inside each primitive: A = bits [5:4], B = [3:2], C = [1:0].
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NPRIM; g++) begin : g_ram
    logic [1:0] mem_a [DEPTH];
    logic [1:0] mem_b [DEPTH];
    logic [1:0] mem_c [DEPTH];

    // NOTE: the RAM arrays have no reset. Distributed RAM cannot be cleared in
    // one cycle, and the pointers and level already make stale contents
    // unreachable.
    always_ff @(posedge clock_i) begin
      if (wr_ok) begin
        mem_a[wptr] <= data_i[6*g+5 -: 2];
        mem_b[wptr] <= data_i[6*g+3 -: 2];
        mem_c[wptr] <= data_i[6*g+1 -: 2];
      end
    end

    // Asynchronous read (DOA/DOB/DOC).
    assign ram_dout[6*g+5 -: 2] = mem_a[rptr];
    assign ram_dout[6*g+3 -: 2] = mem_b[rptr];
    assign ram_dout[6*g+1 -: 2] = mem_c[rptr];
  end

  // ---------------------------------------------------------------------------
  // Pointers, level, read register and sticky error flags.
  // The pointers are 5 bits wide, so they wrap from 31 to 0 without extra logic.
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments, so every branch sees
  // the pre-edge values of level/pointers and the order of statements does not
  // matter.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 5'd1;
      end

      if (rd_ok) begin
        rptr    <= rptr + 5'd1;
        data_o  <= ram_dout;
        valid_o <= 1'b1;
      end else begin
        valid_o <= 1'b0;
      end

      case ({wr_ok, rd_ok})
        2'b10:   level <= level + 6'd1;
        2'b01:   level <= level - 6'd1;
        default: level <= level;
      endcase

      if (write_i && !wr_ok) begin
        overflow_o <= 1'b1;
      end
      if (read_i && empty_o) begin
        underflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for dram_fifo_ctrl (WIDTH=12, two RAM primitives).
// The reference model is a queue plus sticky flags. Every output is compared
// after each clock edge, with a table-driven opening sequence and directed
// corner cases, followed by random traffic.
// -----------------------------------------------------------------------------
module tb_dram_fifo_ctrl;

  localparam int W      = 12;
  localparam int AFULL  = 28;
  localparam int AEMPTY = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr;
  logic [W-1:0] din;
  logic         rd;
  logic [W-1:0] dout;
  logic         valid, empty, full, afull, aempty, ovf, udf;
  logic [5:0]   level;

  always #5 clk = ~clk;

  dram_fifo_ctrl #(.WIDTH(W), .AFULL(AFULL), .AEMPTY(AEMPTY)) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .write_i        (wr),
    .data_i         (din),
    .read_i         (rd),
    .data_o         (dout),
    .valid_o        (valid),
    .empty_o        (empty),
    .full_o         (full),
    .almost_full_o  (afull),
    .almost_empty_o (aempty),
    .level_o        (level),
    .overflow_o     (ovf),
    .underflow_o    (udf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [W-1:0] mq[$];
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_ovf;
  logic         m_udf;

  typedef struct {
    logic         w;
    logic         r;
    logic [W-1:0] d;
    logic [5:0]   exp_level;
    logic         exp_valid;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // One clock edge of the FIFO rules, computed from the queue occupancy.
  task automatic model_step(input logic w, input logic r, input logic [W-1:0] d);
    bit was_empty = (mq.size() == 0);
    bit was_full  = (mq.size() == 32);
    bit pop_ok    = r && !was_empty;
    bit push_ok   = w && (!was_full || r);
    if (pop_ok) begin
      m_data  = mq.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (push_ok) mq.push_back(d);
    if (w && !push_ok) m_ovf = 1'b1;
    if (r && was_empty) m_udf = 1'b1;
  endtask

  task automatic check_all(input string tag);
    int n = mq.size();
    check({tag, ".level"},  32'(level),  32'(n));
    check({tag, ".empty"},  32'(empty),  32'(n == 0));
    check({tag, ".full"},   32'(full),   32'(n == 32));
    check({tag, ".afull"},  32'(afull),  32'(n >= AFULL));
    check({tag, ".aempty"}, 32'(aempty), 32'(n <= AEMPTY));
    check({tag, ".valid"},  32'(valid),  32'(m_valid));
    check({tag, ".data"},   32'(dout),   32'(m_data));
    check({tag, ".ovf"},    32'(ovf),    32'(m_ovf));
    check({tag, ".udf"},    32'(udf),    32'(m_udf));
  endtask

  // Called just after a falling edge: drive, take one rising edge, compare,
  // and return at the next falling edge.
  task automatic cycle(input string tag, input logic w, input logic r, input logic [W-1:0] d);
    wr  = w;
    rd  = r;
    din = d;
    model_step(w, r, d);
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    wr  = 1'b0;
    rd  = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    wr  = 1'b0;
    rd  = 1'b0;
    din = '0;
    model_reset();

    // Push 0x01..0x05, then pop 5: expected values written out by hand.
    for (int i = 0; i < 5; i++) begin
      tbl[i]   = '{1'b1, 1'b0, W'(i + 1), 6'(i + 1), 1'b0, '0};
      tbl[i+5] = '{1'b0, 1'b1, '0, 6'(4 - i), 1'b1, W'(i + 1)};
    end

    @(negedge clk);
    do_reset("reset");

    // ---- table-driven: 5 pushes, 5 pops --------------------------------------
    for (int i = 0; i < 10; i++) begin
      cycle("tbl", tbl[i].w, tbl[i].r, tbl[i].d);
      check("tbl.level", 32'(level), 32'(tbl[i].exp_level));
      check("tbl.valid", 32'(valid), 32'(tbl[i].exp_valid));
      check("tbl.data",  32'(dout),  32'(tbl[i].exp_data));
    end
    check("tbl.empty_end", 32'(empty), 32'd1);

    // ---- fill to 32, overflow, drain -----------------------------------------
    for (int i = 0; i < 32; i++) begin
      cycle("fill", 1'b1, 1'b0, W'(i));
      check("fill.afull", 32'(afull), 32'(i + 1 >= 28));
    end
    check("fill.full", 32'(full), 32'd1);
    cycle("ovf", 1'b1, 1'b0, W'('h3F));
    check("ovf.flag",  32'(ovf),   32'd1);
    check("ovf.level", 32'(level), 32'd32);
    for (int i = 0; i < 32; i++) begin
      cycle("drain", 1'b0, 1'b1, '0);
      check("drain.data", 32'(dout), 32'(i));
    end

    // ---- full-rate push+pop at level 32 across pointer wraps -----------------
    for (int i = 0; i < 32; i++) cycle("refill", 1'b1, 1'b0, W'(12'h100 + i));
    for (int i = 0; i < 40; i++) begin
      cycle("stream", 1'b1, 1'b1, W'(12'h200 + i));
      check("stream.level", 32'(level), 32'd32);
      check("stream.full",  32'(full),  32'd1);
      check("stream.data",  32'(dout),  (i < 32) ? 32'(12'h100 + i) : 32'(12'h200 + i - 32));
    end
    for (int i = 0; i < 32; i++) cycle("drain2", 1'b0, 1'b1, '0);

    // ---- pop+push on empty: no bypass ----------------------------------------
    do_reset("reset2");
    cycle("nobypass", 1'b1, 1'b1, W'('h2A));
    check("nobypass.udf",   32'(udf),   32'd1);
    check("nobypass.valid", 32'(valid), 32'd0);
    check("nobypass.level", 32'(level), 32'd1);
    cycle("nobypass_pop", 1'b0, 1'b1, '0);
    check("nobypass.data", 32'(dout), 32'h2A);

    // ---- slice mapping across both primitives --------------------------------
    cycle("wide", 1'b1, 1'b0, 12'hABC);
    cycle("wide", 1'b1, 1'b0, 12'h123);
    cycle("wide", 1'b0, 1'b1, '0);
    check("wide.first", 32'(dout), 32'hABC);
    cycle("wide", 1'b0, 1'b1, '0);
    check("wide.second", 32'(dout), 32'h123);

    // ---- asynchronous reset mid-stream ---------------------------------------
    for (int i = 0; i < 10; i++) cycle("fill10", 1'b1, 1'b0, W'(12'h300 + i));
    cycle("prepop", 1'b0, 1'b1, '0);
    check("prepop.valid", 32'(valid), 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;  // still well before the next rising edge
    check_all("async_rst");
    check("async_rst.valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle("post_rst", 1'b1, 1'b0, W'('h15));
    cycle("post_rst", 1'b0, 1'b1, '0);
    check("post_rst.data", 32'(dout), 32'h15);

    // ---- random traffic with shifting push/pop bias --------------------------
    do_reset("reset3");
    for (int i = 0; i < 3000; i++) begin
      int phase = (i / 250) % 3;
      int pw    = (phase == 0) ? 80 : (phase == 1) ? 20 : 50;
      int pr    = 100 - pw;
      cycle("rand",
            1'($urandom_range(0, 99) < pw),
            1'($urandom_range(0, 99) < pr),
            W'($urandom_range(0, (1 << W) - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
